// File: rtl/gamepad_step_unit_pkg.sv
// Shared definitions for the gamepad step unit: command encoding, gamepad
// bit positions, mode encoding, the pending-request record and a decoder
// from command code to the one-hot {remover, girar, avancar} outputs.
package gamepad_step_unit_pkg;

  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    CMD_AVANCAR = 2'd1,
    CMD_GIRAR   = 2'd2,
    CMD_REMOVER = 2'd3
  } cmd_t;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_t;

  localparam int PAD_WIDTH   = 12;
  localparam int PAD_AVANCAR = 0;
  localparam int PAD_GIRAR   = 1;
  localparam int PAD_REMOVER = 2;
  localparam int PAD_AUTO    = 11;

  // Slots of the five conditioned inputs inside the debouncer bank.
  localparam int IDX_AVANCAR = 0;
  localparam int IDX_GIRAR   = 1;
  localparam int IDX_REMOVER = 2;
  localparam int IDX_AUTO    = 3;
  localparam int IDX_MCLK    = 4;
  localparam int NUM_INPUTS  = 5;

  typedef struct packed {
    logic valid;
    cmd_t cmd;
  } pending_t;

  // Returns {remover, girar, avancar}; CMD_NONE decodes to all zero.
  function automatic logic [2:0] cmd_onehot(input cmd_t cmd);
    logic [2:0] bits;
    bits = 3'b000;
    case (cmd)
      CMD_AVANCAR: bits = 3'b001;
      CMD_GIRAR:   bits = 3'b010;
      CMD_REMOVER: bits = 3'b100;
      default:     bits = 3'b000;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/gamepad_step_unit_input_debounce.sv
// input_debounce: conditions one raw asynchronous input.
//   2-FF synchronizer -> debouncer (stable + counter) -> rising-edge detect.
// Ports:
//   clock, reset (async active-low)
//   raw         : asynchronous input
//   stable      : debounced level (registered)
//   stable_next : value stable takes at the next edge (lets other state
//                 update in the same edge as stable)
//   rise        : stable went 0->1 at the last edge (one cycle)
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic stable_next,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          stable_d_q;
  logic          update;

  // The counter already holds DEBOUNCE_CYCLES-1 mismatching cycles, so this
  // mismatching cycle is the DEBOUNCE_CYCLES-th one.
  assign update = (sync2_q != stable_q) && (cnt_q == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      stable_q   <= 1'b0;
      stable_d_q <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      stable_d_q <= stable_q;
      if (update) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else if (sync2_q != stable_q) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign stable      = stable_q;
  assign stable_next = update ? sync2_q : stable_q;
  assign rise        = stable_q & ~stable_d_q;

endmodule

// File: rtl/gamepad_step_unit.sv
// gamepad_step_unit: conditions the gamepad and manual-clock inputs, chooses
// manual or automatic stepping and emits one-cycle step pulses to the map
// engine, released only while v_sync is high.
// Ports:
//   clock, reset (async active-low)
//   gamepad_input[11:0] : [0] avancar, [1] girar, [2] remover, [11] auto level
//   manual_clock        : single-step button
//   v_sync              : release window (high = step may be released)
//   clock_robo          : one-cycle step pulse
//   avancar/girar/remover : command qualifiers, only during clock_robo
//   flag_mode           : 1 = auto mode; a direct decode of the mode FSM state
module gamepad_step_unit
  import gamepad_step_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PAD_WIDTH-1:0] gamepad_input,
  input  logic                 manual_clock,
  input  logic                 v_sync,
  output logic                 clock_robo,
  output logic                 avancar,
  output logic                 girar,
  output logic                 remover,
  output logic                 flag_mode
);

  localparam int ACW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [ACW-1:0] AUTO_RELOAD = ACW'(AUTO_PERIOD - 1);

  // ---------------- input conditioning ----------------
  logic [NUM_INPUTS-1:0] raw_bits;
  logic [NUM_INPUTS-1:0] stable;
  logic [NUM_INPUTS-1:0] stable_next;
  logic [NUM_INPUTS-1:0] rise;

  assign raw_bits[IDX_AVANCAR] = gamepad_input[PAD_AVANCAR];
  assign raw_bits[IDX_GIRAR]   = gamepad_input[PAD_GIRAR];
  assign raw_bits[IDX_REMOVER] = gamepad_input[PAD_REMOVER];
  assign raw_bits[IDX_AUTO]    = gamepad_input[PAD_AUTO];
  assign raw_bits[IDX_MCLK]    = manual_clock;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_deb
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock       (clock),
      .reset       (reset),
      .raw         (raw_bits[i]),
      .stable      (stable[i]),
      .stable_next (stable_next[i]),
      .rise        (rise[i])
    );
  end

  // Pad bits 10:3 carry nothing for this stage; only the auto debouncer's
  // look-ahead and the button edges are consumed.
  logic unused_bits;
  assign unused_bits = ^{gamepad_input[10:3], stable, rise[IDX_AUTO],
                         stable_next[IDX_AVANCAR], stable_next[IDX_GIRAR],
                         stable_next[IDX_REMOVER], stable_next[IDX_MCLK]};

  // ---------------- mode FSM ----------------
  // Follows the look-ahead of the debounced auto bit so the state register
  // (and flag_mode) changes in the same edge as the debounced level.
  mode_t mode_q;
  mode_t mode_next;
  logic  mode_change;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mode_q <= MODE_MANUAL;
    else        mode_q <= mode_next;
  end

  always_comb begin
    mode_next = stable_next[IDX_AUTO] ? MODE_AUTO : MODE_MANUAL;
  end

  always_comb begin
    flag_mode   = (mode_q == MODE_AUTO);
    mode_change = (mode_next != mode_q);
  end

  // ---------------- request generation ----------------
  logic [ACW-1:0] auto_cnt_q;
  logic           req_valid;
  cmd_t           req_cmd;

  always_comb begin
    req_valid = 1'b0;
    req_cmd   = CMD_NONE;
    if (mode_q == MODE_MANUAL) begin
      if (rise[IDX_REMOVER]) begin
        req_valid = 1'b1;
        req_cmd   = CMD_REMOVER;
      end else if (rise[IDX_GIRAR]) begin
        req_valid = 1'b1;
        req_cmd   = CMD_GIRAR;
      end else if (rise[IDX_AVANCAR]) begin
        req_valid = 1'b1;
        req_cmd   = CMD_AVANCAR;
      end else if (rise[IDX_MCLK]) begin
        req_valid = 1'b1;
      end
    end else begin
      req_valid = (auto_cnt_q == '0);
    end
  end

  // Runs in auto mode whether or not the pending slot is free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      auto_cnt_q <= AUTO_RELOAD;
    end else if (mode_change) begin
      auto_cnt_q <= AUTO_RELOAD;
    end else if (mode_q == MODE_AUTO) begin
      if (auto_cnt_q == '0) auto_cnt_q <= AUTO_RELOAD;
      else                  auto_cnt_q <= auto_cnt_q - ACW'(1);
    end
  end

  // ---------------- pending slot and release ----------------
  // Handshake: pend_q.valid is the producer's valid, v_sync is the
  // consumer's ready. A step transfers in a cycle where both are high;
  // valid stays asserted with its cmd unchanged until that transfer, and
  // while valid is high any further request is dropped.
  pending_t pend_q;
  logic     release_step;

  assign release_step = pend_q.valid && v_sync && !mode_change;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else if (mode_change) begin
      pend_q <= '0;
    end else if (release_step) begin
      pend_q.valid <= 1'b0;
    end else if (!pend_q.valid && req_valid) begin
      pend_q.valid <= 1'b1;
      pend_q.cmd   <= req_cmd;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clock_robo <= 1'b0;
      avancar    <= 1'b0;
      girar      <= 1'b0;
      remover    <= 1'b0;
    end else begin
      clock_robo <= release_step;
      if (release_step) {remover, girar, avancar} <= cmd_onehot(pend_q.cmd);
      else              {remover, girar, avancar} <= 3'b000;
    end
  end

endmodule

// File: tb/tb_gamepad_step_unit.sv
// Directed bench for gamepad_step_unit (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8).
// Pulses are logged as {cycle, remover, girar, avancar} and compared against
// hand-computed expectations in exp_q.
module tb_gamepad_step_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] gamepad_input;
  logic        manual_clock;
  logic        v_sync;
  logic        clock_robo, avancar, girar, remover, flag_mode;

  gamepad_step_unit #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .gamepad_input (gamepad_input),
    .manual_clock  (manual_clock),
    .v_sync        (v_sync),
    .clock_robo    (clock_robo),
    .avancar       (avancar),
    .girar         (girar),
    .remover       (remover),
    .flag_mode     (flag_mode)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clock = ~clock;

  logic [31:0] cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];
  logic [34:0] obs_q[$];
  int checks = 0;
  int errors = 0;
  int viol   = 0;

  always @(negedge clock) begin
    if (clock_robo) obs_q.push_back({cyc, remover, girar, avancar});
    if ($countones({remover, girar, avancar}) > 1 ||
        ({remover, girar, avancar} != 3'b000 && !clock_robo))
      viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_pulse(input logic [31:0] at, input logic [2:0] cmd);
    exp_q.push_back({at, cmd});
  endtask

  task automatic score(input string tag);
    #1;
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check(tag, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  logic [31:0] t0;

  initial begin
    // ---------- reset with all pad bits high ----------
    reset = 1'b0; gamepad_input = 12'hFFF; manual_clock = 1'b0; v_sync = 1'b0;
    tick(2);
    check("rst_outputs", {clock_robo, avancar, girar, remover, flag_mode}, 5'b0);
    reset = 1'b1;
    tick(5);
    check("rst_flag_early", flag_mode, 1'b0);
    check("rst_pulse_early", {clock_robo, avancar, girar, remover}, 4'b0);
    tick(1);
    check("rst_flag_debounced", flag_mode, 1'b1);
    obs_q.delete();

    gamepad_input = 12'h000; reset = 1'b0;
    tick(2);
    reset = 1'b1; v_sync = 1'b1;
    tick(10);
    score("idle");

    // ---------- manual avancar: latency 8 ----------
    t0 = cyc; gamepad_input[0] = 1'b1;
    tick(20);
    gamepad_input[0] = 1'b0;
    tick(15);
    expect_pulse(t0 + 8, 3'b001);
    score("avancar");

    // ---------- 3-cycle glitch is filtered ----------
    gamepad_input[0] = 1'b1;
    tick(3);
    gamepad_input[0] = 1'b0;
    tick(20);
    score("glitch");

    // ---------- manual_clock single step ----------
    t0 = cyc; manual_clock = 1'b1;
    tick(10);
    manual_clock = 1'b0;
    tick(15);
    expect_pulse(t0 + 8, 3'b000);
    score("manual_clock");

    // ---------- priority and drop while v_sync low ----------
    v_sync = 1'b0; t0 = cyc; gamepad_input = 12'h006;
    tick(12);
    gamepad_input = 12'h007;
    tick(12);
    v_sync = 1'b1;
    tick(10);
    gamepad_input = 12'h000;
    tick(15);
    expect_pulse(t0 + 25, 3'b100);
    score("priority_drop");

    // ---------- auto mode, pad[0] toggling ignored ----------
    t0 = cyc; gamepad_input = 12'h800;
    tick(5);
    check("auto_flag_early", flag_mode, 1'b0);
    tick(1);
    check("auto_flag", flag_mode, 1'b1);
    for (int k = 0; k < 4; k++) begin
      gamepad_input[0] = 1'b1;
      tick(10);
      gamepad_input[0] = 1'b0;
      tick(10);
    end
    tick(14);
    for (int k = 0; k < 11; k++) expect_pulse(t0 + 15 + 8 * k, 3'b000);
    score("auto");

    // ---------- mode switch with auto request pending ----------
    v_sync = 1'b0;
    tick(10);
    gamepad_input = 12'h000;
    tick(5);
    check("switch_flag_hold", flag_mode, 1'b1);
    tick(1);
    check("switch_flag_manual", flag_mode, 1'b0);
    v_sync = 1'b1;
    tick(20);
    score("mode_switch");

    // ---------- async reset during a pulse ----------
    gamepad_input = 12'h800;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (clock_robo) break;
    end
    check("async_pulse_seen", clock_robo, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("async_pulse_cleared", clock_robo, 1'b0);
    check("async_mode_manual", flag_mode, 1'b0);
    check("async_cmd_cleared", {avancar, girar, remover}, 3'b000);
    tick(2);
    reset = 1'b1;
    tick(2);
    obs_q.delete();

    check("onehot_qualifiers", 64'(viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gamepad_step_unit.md
# gamepad_step_unit

Input-conditioning and step-generation stage directly upstream of the robot/map engine. Synchronizes and debounces the raw gamepad and manual-clock inputs, selects automatic or manual mode, and emits one-cycle robot step pulses (`clock_robo`) with an optional manual move command (`avancar`/`girar`/`remover`). Steps are released only while `v_sync` is high, so map updates land in vertical blanking.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized cycles before a debounced input changes (sim value; board build overrides).
- `AUTO_PERIOD`, 8: clock cycles between step requests in auto mode; minimum 2.
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `gamepad_input`  in  12  raw pad: [0] avancar, [1] girar, [2] remover, [11] auto-mode level, [10:3] ignored.
- `manual_clock`  in  1  raw single-step button.
- `v_sync`  in  1  step-release window (high = release allowed).
- `clock_robo`  out  1  one-cycle step pulse to the map engine.
- `avancar`, `girar`, `remover`  out  1 each  command qualifiers; valid only in the `clock_robo` cycle, else 0.
- `flag_mode`  out  1  1 = auto mode (debounced `gamepad_input[11]`).

## Operation
- Five conditioned inputs: pad bits 0, 1, 2, 11 and `manual_clock`. Each passes a 2-FF synchronizer, then a debouncer holding `stable` and a saturating counter: counter increments while sync ≠ stable, clears when equal; reaching `DEBOUNCE_CYCLES` updates `stable` and clears the counter.
- Rising-edge detect on debounced bits 0, 1, 2 and `manual_clock`: `rise = stable & ~stable_d`.
- Mode FSM, two states: MANUAL (reset), AUTO. AUTO when debounced bit 11 = 1, MANUAL when 0. On any mode change: clear pending request and auto counter in that same cycle.
- Single-entry pending register {valid, cmd[1:0]}; cmd encoding NONE, AVANCAR, GIRAR, REMOVER.
- MANUAL: rising edge of remover/girar/avancar sets pending with that cmd; priority remover > girar > avancar on simultaneous edges. `manual_clock` rise sets pending with NONE (single step); a command edge in the same cycle wins.
- AUTO: down-counter loads `AUTO_PERIOD-1`; at 0 sets pending with NONE and reloads. Command-button and `manual_clock` edges are ignored.
- Pending already valid: new requests are dropped (no queueing); auto counter keeps running.
- Release: when pending valid and `v_sync`=1, next cycle drives `clock_robo`=1 plus the decoded command bit for exactly one cycle, and clears pending. Pending holds indefinitely while `v_sync`=0.
- At most one of `avancar`/`girar`/`remover` high at any time.

## Timing
- Reset (async assert, sync release): all outputs 0, synchronizers/debouncers/stable = 0, FSM MANUAL, pending empty, auto counter = `AUTO_PERIOD-1`.
- Input stable from cycle t: sync output at t+2, debounced `stable` changes at t+2+`DEBOUNCE_CYCLES`, pending set at the following edge, and `clock_robo` pulses the edge after that if `v_sync` is high. Total manual latency = `DEBOUNCE_CYCLES`+4 cycles.
- `flag_mode` is registered with `stable[11]`, with no extra delay.
- Auto mode with `v_sync` held high: one `clock_robo` every `AUTO_PERIOD` cycles. First pulse `AUTO_PERIOD`+1 cycles after `flag_mode` rises.
- Glitches shorter than `DEBOUNCE_CYCLES` after synchronization produce no change.
- Reset asserted mid-pulse clears `clock_robo` immediately (asynchronous).

## Structure
- Shared package/header: cmd encoding constants (CMD_NONE=0, CMD_AVANCAR=1, CMD_GIRAR=2, CMD_REMOVER=3), gamepad bit indices (PAD_AVANCAR=0, PAD_GIRAR=1, PAD_REMOVER=2, PAD_AUTO=11), mode encoding.
- Sub-module `input_debounce` (parameter `DEBOUNCE_CYCLES`): 2-FF sync + counter + stable + rise output. Instantiate it five times.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with pad=12'hFFF. All outputs 0 during and after reset until debouncing completes.
- Manual avancar: `v_sync`=1, pulse pad[0] high for 20 cycles. Exactly one `clock_robo` with `avancar`=1, 8 cycles after the rise. A 3-cycle pad[0] glitch produces no pulse.
- Priority/drop: pad[2] and pad[1] rise in the same cycle. One pulse with `remover`=1, `girar`=0. A pad[0] rise while `v_sync`=0 holds pending is dropped. When `v_sync` goes high, exactly one `remover` pulse follows.
- Auto mode: pad[11]=1, `v_sync`=1 for 100 cycles. `flag_mode`=1 after 6 cycles, then `clock_robo` every 8 cycles with all command bits 0. Pad[0] edges are ignored.
- Mode switch: drop pad[11] while an auto request is pending with `v_sync`=0. Pending is cleared, `flag_mode`→0, and raising `v_sync` produces no pulse.
- Async reset mid-operation: assert `reset` in the `clock_robo` cycle. Pulse falls without waiting for a clock edge, FSM returns to MANUAL.
